// File: rtl/fabric_instr_loader_pkg.sv
// Shared types and constants for the per-row instruction loader.
package fabric_instr_loader_pkg;

  localparam int INSTR_DATA_WIDTH = 32;
  localparam int INSTR_ADDR_WIDTH = 6;
  localparam int INSTR_HOPS_WIDTH = 4;
  localparam int COLS             = 2;

  // Record width on the host side: {hops, addr, data}.
  localparam int INSTR_REC_WIDTH  = INSTR_HOPS_WIDTH + INSTR_ADDR_WIDTH + INSTR_DATA_WIDTH;

  // The last instruction needs one cycle per cell register plus one to leave the row.
  localparam int SETTLE_CYCLES    = COLS + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CALL,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [INSTR_HOPS_WIDTH-1:0] hops;
    logic [INSTR_ADDR_WIDTH-1:0] addr;
    logic [INSTR_DATA_WIDTH-1:0] data;
    logic                        last;
  } instr_rec_t;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO of instruction records. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module loader_fifo
  import fabric_instr_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  instr_rec_t wr_rec,
  input  logic       pop,
  output instr_rec_t rd_rec,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  instr_rec_t     mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_rec = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush discards anything left once an episode's last record is issued.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array write.
  // NOTE: the array has no reset; pointers define validity, and a resettable RAM costs flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
  end

endmodule

// File: rtl/fabric_instr_loader.sv
// Per-row loader: buffers host instruction records, streams them onto the
// row's instr_* chain, waits for them to settle, calls the row and then
// waits for its ret handshake (or the watchdog) before reporting done.
module fabric_instr_loader
  import fabric_instr_loader_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [TIMEOUT_WIDTH-1:0]    timeout_limit,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTR_REC_WIDTH-1:0]  in_data,
  input  logic                        in_last,
  output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
  output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
  output logic                        instr_en_out,
  output logic                        call,
  input  logic                        ret,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_t                      state_q, state_d;
  logic [SW-1:0]               settle_cnt_q, settle_cnt_d;
  logic [TIMEOUT_WIDTH-1:0]    wd_q, wd_d, wd_inc;
  logic                        arm_q, arm_d;
  logic                        timeout_q, timeout_d;

  logic [INSTR_DATA_WIDTH-1:0] instr_data_q;
  logic [INSTR_ADDR_WIDTH-1:0] instr_addr_q;
  logic [INSTR_HOPS_WIDTH-1:0] instr_hops_q;
  logic                        instr_en_q;

  instr_rec_t                  push_rec, fifo_head;
  logic                        fifo_full, fifo_empty;
  logic                        push, pop, pop_last;

  assign in_ready = (state_q == LOAD) && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == LOAD) && !fifo_empty;
  assign pop_last = pop && fifo_head.last;
  assign push_rec = instr_rec_t'({in_data, in_last});

  // Watchdog advances by one and sticks at all-ones instead of wrapping.
  assign wd_inc   = (wd_q == '1) ? wd_q : wd_q + 1'b1;

  loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (pop_last),
    .push   (push),
    .wr_rec (push_rec),
    .pop    (pop),
    .rd_rec (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      wd_q         <= '0;
      arm_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      wd_q         <= wd_d;
      arm_q        <= arm_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic for the episode sequence.
  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    wd_d         = wd_q;
    arm_d        = arm_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (pop_last) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = CALL;
          wd_d    = '0;   // watchdog reads zero during the call cycle
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      CALL: begin
        // The call cycle counts as the first elapsed cycle of the run.
        wd_d      = wd_inc;
        arm_d     = 1'b0;
        timeout_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        wd_d = wd_inc;
        if (!ret) arm_d = 1'b1;
        if (arm_q && ret) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if ((timeout_limit != '0) && (wd_inc >= timeout_limit)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Instruction output register: strobe per pop, data fields hold between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_data_q <= '0;
      instr_addr_q <= '0;
      instr_hops_q <= '0;
      instr_en_q   <= 1'b0;
    end else begin
      instr_en_q <= pop;
      if (pop) begin
        instr_data_q <= fifo_head.data;
        instr_addr_q <= fifo_head.addr;
        instr_hops_q <= fifo_head.hops;
      end
    end
  end

  assign instr_data_out = instr_data_q;
  assign instr_addr_out = instr_addr_q;
  assign instr_hops_out = instr_hops_q;
  assign instr_en_out   = instr_en_q;
  assign call           = (state_q == CALL);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign timeout        = (state_q == DONE) && timeout_q;

endmodule
